// File: rtl/bf16_addsub_pipe.sv
// rtl/bf16_addsub_pipe.sv - four-stage bf16 adder/subtractor with valid/ready handshake
`timescale 1ns/1ps
module bf16_addsub_pipe #(
    parameter int G     = 3,
    parameter int TAG_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [15:0]      a,
    input  logic [15:0]      b,
    input  logic             op,
    input  logic [TAG_W-1:0] tag_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [15:0]      result,
    output logic [TAG_W-1:0] tag_out,
    output logic [3:0]       flags
);
    // Working mantissa: hidden bit, 7 fraction bits, G guard bits (lowest is sticky)
    localparam int          W      = 8 + G;
    localparam int          SW     = $clog2(W + 1);
    localparam logic [7:0]  SH_MAX = 8'(W);
    localparam logic [15:0] QNAN   = 16'h7FC0;

    // Whole pipeline freezes only while a finished result waits on downstream
    logic adv;
    logic out_valid_q;
    assign adv      = ~(out_valid_q & ~out_ready);
    assign in_ready = adv & ~reset;

    // Stage 1: decode/align
    logic             s1_valid_d, s1_valid_q;
    logic             s1_sign_d, s1_sign_q, s1_zsign_d, s1_zsign_q, s1_sub_d, s1_sub_q;
    logic             s1_spec_d, s1_spec_q, s1_inv_d, s1_inv_q;
    logic [15:0]      s1_spec_res_d, s1_spec_res_q;
    logic [7:0]       s1_exp_d, s1_exp_q;
    logic [W-1:0]     s1_mb_d, s1_mb_q, s1_ms_d, s1_ms_q;
    logic [TAG_W-1:0] s1_tag_d, s1_tag_q;
    // Stage 2: add
    logic             s2_valid_d, s2_valid_q;
    logic             s2_sign_d, s2_sign_q, s2_zsign_d, s2_zsign_q;
    logic             s2_spec_d, s2_spec_q, s2_inv_d, s2_inv_q;
    logic [15:0]      s2_spec_res_d, s2_spec_res_q;
    logic [7:0]       s2_exp_d, s2_exp_q;
    logic [W:0]       s2_sum_d, s2_sum_q;
    logic [TAG_W-1:0] s2_tag_d, s2_tag_q;
    // Stage 3: normalize
    logic             s3_valid_d, s3_valid_q;
    logic             s3_sign_d, s3_sign_q, s3_zsign_d, s3_zsign_q, s3_zero_d, s3_zero_q;
    logic             s3_spec_d, s3_spec_q, s3_inv_d, s3_inv_q;
    logic [15:0]      s3_spec_res_d, s3_spec_res_q;
    logic [9:0]       s3_exp_d, s3_exp_q;
    logic [W-1:0]     s3_man_d, s3_man_q;
    logic [TAG_W-1:0] s3_tag_d, s3_tag_q;
    // Stage 4: round/pack (output register)
    logic             out_valid_d;
    logic [15:0]      result_d, result_q;
    logic [TAG_W-1:0] tag_out_d, tag_out_q;
    logic [3:0]       flags_d, flags_q;

    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign tag_out   = tag_out_q;
    assign flags     = flags_q;

    function automatic logic [SW-1:0] lzc(input logic [W-1:0] v);
        logic [SW-1:0] n;
        n = SW'(W);
        for (int i = 0; i < W; i++) begin
            if (v[i]) n = SW'(W - 1 - i);
        end
        return n;
    endfunction

    logic          sa, sb, a_zero, b_zero, a_inf, b_inf, a_nan, b_nan, swap;
    logic [14:0]   mag_a, mag_b;
    logic [7:0]    e_small, d, sh_sat;
    logic [SW-1:0] sh;
    logic [W-1:0]  m_small;
    logic [2*W-1:0] wide;

    // Decode operands, pick the larger magnitude, right-shift the other with sticky collection
    always_comb begin
        sa     = a[15];
        sb     = b[15] ^ op;
        a_zero = (a[14:7] == 8'h00);
        b_zero = (b[14:7] == 8'h00);
        a_inf  = (a[14:7] == 8'hFF) && (a[6:0] == 7'h00);
        b_inf  = (b[14:7] == 8'hFF) && (b[6:0] == 7'h00);
        a_nan  = (a[14:7] == 8'hFF) && (a[6:0] != 7'h00);
        b_nan  = (b[14:7] == 8'hFF) && (b[6:0] != 7'h00);
        mag_a  = a_zero ? 15'h0000 : a[14:0];
        mag_b  = b_zero ? 15'h0000 : b[14:0];
        swap   = (mag_b > mag_a);

        s1_sign_d  = swap ? sb : sa;
        s1_zsign_d = sa & sb;
        s1_sub_d   = sa ^ sb;
        s1_exp_d   = swap ? mag_b[14:7] : mag_a[14:7];
        e_small    = swap ? mag_a[14:7] : mag_b[14:7];
        s1_mb_d    = swap ? {|mag_b[14:7], mag_b[6:0], {G{1'b0}}}
                          : {|mag_a[14:7], mag_a[6:0], {G{1'b0}}};
        m_small    = swap ? {|mag_a[14:7], mag_a[6:0], {G{1'b0}}}
                          : {|mag_b[14:7], mag_b[6:0], {G{1'b0}}};
        d          = s1_exp_d - e_small;
        sh_sat     = (d > SH_MAX) ? SH_MAX : d;
        sh         = sh_sat[SW-1:0];
        wide       = {m_small, {W{1'b0}}} >> sh;
        s1_ms_d    = wide[2*W-1:W] | {{(W-1){1'b0}}, |wide[W-1:0]};

        s1_spec_d     = 1'b0;
        s1_inv_d      = 1'b0;
        s1_spec_res_d = 16'h0000;
        if (a_nan || b_nan) begin
            s1_spec_d     = 1'b1;
            s1_spec_res_d = QNAN;
        end else if (a_inf && b_inf && (sa != sb)) begin
            s1_spec_d     = 1'b1;
            s1_inv_d      = 1'b1;
            s1_spec_res_d = QNAN;
        end else if (a_inf) begin
            s1_spec_d     = 1'b1;
            s1_spec_res_d = {sa, 15'h7F80};
        end else if (b_inf) begin
            s1_spec_d     = 1'b1;
            s1_spec_res_d = {sb, 15'h7F80};
        end

        s1_tag_d   = tag_in;
        s1_valid_d = in_valid & in_ready;
    end

    // Magnitude add or subtract; the larger operand is always the minuend
    always_comb begin
        s2_sum_d      = s1_sub_q ? ({1'b0, s1_mb_q} - {1'b0, s1_ms_q})
                                 : ({1'b0, s1_mb_q} + {1'b0, s1_ms_q});
        s2_valid_d    = s1_valid_q;
        s2_sign_d     = s1_sign_q;
        s2_zsign_d    = s1_zsign_q;
        s2_spec_d     = s1_spec_q;
        s2_inv_d      = s1_inv_q;
        s2_spec_res_d = s1_spec_res_q;
        s2_exp_d      = s1_exp_q;
        s2_tag_d      = s1_tag_q;
    end

    logic [SW-1:0] lz;

    // Bring the leading one to the hidden-bit position, keeping sticky on a right shift
    always_comb begin
        lz = lzc(s2_sum_q[W-1:0]);
        if (s2_sum_q[W]) begin
            s3_man_d = {s2_sum_q[W:2], s2_sum_q[1] | s2_sum_q[0]};
            s3_exp_d = {2'b00, s2_exp_q} + 10'd1;
        end else begin
            s3_man_d = s2_sum_q[W-1:0] << lz;
            s3_exp_d = {2'b00, s2_exp_q} - 10'(lz);
        end
        s3_zero_d     = (s2_sum_q == '0);
        s3_valid_d    = s2_valid_q;
        s3_sign_d     = s2_sign_q;
        s3_zsign_d    = s2_zsign_q;
        s3_spec_d     = s2_spec_q;
        s3_inv_d      = s2_inv_q;
        s3_spec_res_d = s2_spec_res_q;
        s3_tag_d      = s2_tag_q;
    end

    logic [7:0] kept;
    logic       grd, rnd, stk, up, inexact;
    logic [8:0] rsum;
    logic [9:0] exp_r;

    // Round to nearest even, then resolve specials, zero, overflow and underflow
    always_comb begin
        kept    = s3_man_q[W-1:G];
        grd     = s3_man_q[G-1];
        rnd     = s3_man_q[G-2];
        stk     = |s3_man_q[G-3:0];
        up      = grd & (rnd | stk | kept[0]);
        inexact = grd | rnd | stk;
        rsum    = {1'b0, kept} + {8'h00, up};
        exp_r   = s3_exp_q + {9'h000, rsum[8]};

        result_d = 16'h0000;
        flags_d  = 4'b0000;
        if (s3_spec_q) begin
            result_d = s3_spec_res_q;
            flags_d  = {s3_inv_q, 3'b000};
        end else if (s3_zero_q) begin
            result_d = {s3_zsign_q, 15'h0000};
        end else if (!exp_r[9] && (exp_r >= 10'd255)) begin
            result_d = {s3_sign_q, 15'h7F80};
            flags_d  = 4'b0101;
        end else if (exp_r[9] || (exp_r == 10'd0)) begin
            result_d = {s3_sign_q, 15'h0000};
            flags_d  = 4'b0011;
        end else begin
            result_d = {s3_sign_q, exp_r[7:0], rsum[6:0]};
            flags_d  = {3'b000, inexact};
        end
        out_valid_d = s3_valid_q;
        tag_out_d   = s3_tag_q;
    end

    // Pipeline registers: reset clears valids and output, stall holds everything
    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid_q  <= 1'b0;
            s2_valid_q  <= 1'b0;
            s3_valid_q  <= 1'b0;
            out_valid_q <= 1'b0;
            result_q    <= 16'h0000;
            tag_out_q   <= '0;
            flags_q     <= 4'b0000;
        end else if (adv) begin
            s1_valid_q    <= s1_valid_d;
            s1_sign_q     <= s1_sign_d;
            s1_zsign_q    <= s1_zsign_d;
            s1_sub_q      <= s1_sub_d;
            s1_spec_q     <= s1_spec_d;
            s1_inv_q      <= s1_inv_d;
            s1_spec_res_q <= s1_spec_res_d;
            s1_exp_q      <= s1_exp_d;
            s1_mb_q       <= s1_mb_d;
            s1_ms_q       <= s1_ms_d;
            s1_tag_q      <= s1_tag_d;
            s2_valid_q    <= s2_valid_d;
            s2_sign_q     <= s2_sign_d;
            s2_zsign_q    <= s2_zsign_d;
            s2_spec_q     <= s2_spec_d;
            s2_inv_q      <= s2_inv_d;
            s2_spec_res_q <= s2_spec_res_d;
            s2_exp_q      <= s2_exp_d;
            s2_sum_q      <= s2_sum_d;
            s2_tag_q      <= s2_tag_d;
            s3_valid_q    <= s3_valid_d;
            s3_sign_q     <= s3_sign_d;
            s3_zsign_q    <= s3_zsign_d;
            s3_zero_q     <= s3_zero_d;
            s3_spec_q     <= s3_spec_d;
            s3_inv_q      <= s3_inv_d;
            s3_spec_res_q <= s3_spec_res_d;
            s3_exp_q      <= s3_exp_d;
            s3_man_q      <= s3_man_d;
            s3_tag_q      <= s3_tag_d;
            out_valid_q   <= out_valid_d;
            result_q      <= result_d;
            tag_out_q     <= tag_out_d;
            flags_q       <= flags_d;
        end
    end

endmodule

// File: tb/tb_bf16_addsub_pipe.sv
// tb/tb_bf16_addsub_pipe.sv - directed self-checking bench for bf16_addsub_pipe
`timescale 1ns/1ps
module tb_bf16_addsub_pipe;
    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] a;
    logic [15:0] b;
    logic        op;
    logic [3:0]  tag_in;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] result;
    logic [3:0]  tag_out;
    logic [3:0]  flags;

    int n_pass = 0;
    int n_fail = 0;
    int n_total = 0;
    int issued, recvd, stall_left, seen, valid_seen;

    always #5 clk = ~clk;

    bf16_addsub_pipe #(.G(3), .TAG_W(4)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .op(op), .tag_in(tag_in),
        .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .tag_out(tag_out), .flags(flags)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_total++;
        assert (obs === expv) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic run_one(input string name, input logic [15:0] va, input logic [15:0] vb,
                           input logic vop, input logic [3:0] vtag,
                           input logic [15:0] er, input logic [3:0] ef);
        int lat;
        @(negedge clk);
        a = va; b = vb; op = vop; tag_in = vtag; in_valid = 1'b1; out_ready = 1'b1;
        #1;
        chk({name, " in_ready"}, 32'(in_ready), 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        chk({name, " latency"}, 32'(lat), 32'd4);
        chk({name, " result"}, 32'(result), 32'(er));
        chk({name, " flags"}, 32'(flags), 32'(ef));
        chk({name, " tag"}, 32'(tag_out), 32'(vtag));
    endtask

    initial begin
        reset = 1'b1; in_valid = 1'b0; a = 16'h0; b = 16'h0; op = 1'b0;
        tag_in = 4'h0; out_ready = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset out_valid", 32'(out_valid), 32'd0);
        chk("reset result", 32'(result), 32'd0);
        chk("reset tag_out", 32'(tag_out), 32'd0);
        chk("reset flags", 32'(flags), 32'd0);
        chk("reset in_ready", 32'(in_ready), 32'd0);
        reset = 1'b0;
        #1;
        chk("post-reset in_ready", 32'(in_ready), 32'd1);

        run_one("add 1+1",        16'h3F80, 16'h3F80, 1'b0, 4'h5, 16'h4000, 4'b0000);
        run_one("sub cancel",     16'h3F80, 16'h3F80, 1'b1, 4'h1, 16'h0000, 4'b0000);
        run_one("sub 3-1",        16'h4040, 16'h3F80, 1'b1, 4'h2, 16'h4000, 4'b0000);
        run_one("tie even",       16'h3F80, 16'h3B80, 1'b0, 4'h3, 16'h3F80, 4'b0001);
        run_one("tie odd",        16'h3F81, 16'h3B80, 1'b0, 4'h4, 16'h3F82, 4'b0001);
        run_one("round carry",    16'h3FFF, 16'h3B80, 1'b0, 4'h6, 16'h4000, 4'b0001);
        run_one("overflow",       16'h7F7F, 16'h7F7F, 1'b0, 4'h7, 16'h7F80, 4'b0101);
        run_one("inf-inf",        16'h7F80, 16'hFF80, 1'b0, 4'h8, 16'h7FC0, 4'b1000);
        run_one("nan in",         16'h7FC1, 16'h3F80, 1'b0, 4'h9, 16'h7FC0, 4'b0000);
        run_one("neg inf+1",      16'hFF80, 16'h3F80, 1'b0, 4'hA, 16'hFF80, 4'b0000);
        run_one("1-inf",          16'h3F80, 16'h7F80, 1'b1, 4'hB, 16'hFF80, 4'b0000);
        run_one("-0+-0",          16'h8000, 16'h8000, 1'b0, 4'hC, 16'h8000, 4'b0000);
        run_one("denorm flush",   16'h0001, 16'h3F80, 1'b0, 4'hD, 16'h3F80, 4'b0000);
        run_one("denorm zeros",   16'h8001, 16'h0001, 1'b0, 4'hE, 16'h0000, 4'b0000);
        run_one("shift saturate", 16'h3F80, 16'h0080, 1'b0, 4'hF, 16'h3F80, 4'b0001);
        run_one("underflow",      16'h0100, 16'h00C0, 1'b1, 4'h0, 16'h0000, 4'b0011);

        // Backpressure: six back-to-back ops, downstream stalls 5 cycles at first result
        issued = 0; recvd = 0; stall_left = 0; seen = 0;
        for (int cyc = 0; cyc < 60 && recvd < 6; cyc++) begin
            @(negedge clk);
            if (out_valid && seen == 0) begin
                seen = 1;
                stall_left = 5;
            end
            out_ready = (stall_left == 0);
            in_valid  = (issued < 6);
            a = 16'h4000 + 16'(issued); b = 16'h0000; op = 1'b0; tag_in = 4'(issued);
            #1;
            if (stall_left > 0) begin
                chk("bp stall in_ready", 32'(in_ready), 32'd0);
                chk("bp stall out_valid", 32'(out_valid), 32'd1);
                chk("bp stall result", 32'(result), 32'h4000);
                chk("bp stall tag", 32'(tag_out), 32'd0);
                stall_left--;
            end
            if (in_valid && in_ready) issued++;
            if (out_valid && out_ready) begin
                chk("bp tag order", 32'(tag_out), 32'(recvd));
                chk("bp result", 32'(result), 32'h4000 + 32'(recvd));
                recvd++;
            end
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        chk("bp received count", 32'(recvd), 32'd6);
        @(negedge clk);
        #1;
        chk("bp drained", 32'(out_valid), 32'd0);

        // Reset mid-operation: three ops in flight are discarded
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            a = 16'h3F80; b = 16'h3F80; op = 1'b0; tag_in = 4'(i + 1); in_valid = 1'b1;
        end
        @(negedge clk);
        in_valid = 1'b0;
        reset = 1'b1;
        #1;
        chk("mid reset in_ready", 32'(in_ready), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        valid_seen = 0;
        for (int i = 0; i < 8; i++) begin
            #1;
            if (out_valid) valid_seen++;
            @(negedge clk);
        end
        chk("mid reset no output", 32'(valid_seen), 32'd0);
        run_one("post reset op", 16'h4040, 16'h3F80, 1'b0, 4'h9, 16'h4080, 4'b0000);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
